// File: rtl/uart_tx_unit.sv
// uart_tx_unit: memory-mapped UART transmitter with a small TX FIFO.
//
// Register map (only address[3:2] is decoded):
//   0x0 TXDATA  write pushes wd[7:0] into the FIFO
//   0x4 STATUS  {bit8 parity_cfg, [7:4] count, bit3 overflow, bit2 empty,
//                bit1 full, bit0 busy}; writing bit3=1 clears overflow
//   0x8 CTRL    bit0 enable (read/write, resets to 1)
//   0xC         reads 0, writes ignored
//
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-high reset
//   wd       bus write data
//   address  bus byte address
//   we       bus write strobe
//   rd       bus read data, combinational from address and state
//   tx       serial line, idles high
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit (11-bit frame instead of 10).
module uart_tx_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_CFG = 1'b1;
`else
  localparam logic PARITY_CFG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP  = 3'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             enable_reg;
  logic             overflow_reg;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [7:0]       head;
  logic [3:0]       count_nib;
  logic [1:0]       sel;
  logic full, empty, bit_done, start_ok, pop, push, ovf_event, busy;
  logic txdata_wr, status_wr, ctrl_wr;

  // Address bits outside [3:2] and the upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wd[DATA_WIDTH-1:8], address[DATA_WIDTH-1:4], address[1:0]};

  assign sel       = address[3:2];
  assign txdata_wr = we && (sel == 2'd0);
  assign status_wr = we && (sel == 2'd1);
  assign ctrl_wr   = we && (sel == 2'd2);

  assign full     = (count_reg == DEPTH_C);
  assign empty    = (count_reg == '0);
  assign head     = mem[rd_ptr_reg];
  assign bit_done = (baud_cnt_reg == BAUD_LAST);
  assign start_ok = !empty && enable_reg;

  // A frame is launched from IDLE, or chained directly off the last stop-bit cycle.
  assign pop = start_ok && ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_done));

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = txdata_wr && (!full || pop);
  assign ovf_event = txdata_wr && full && !pop;

  generate
    if (CW >= 4) begin : g_cnt_trunc
      assign count_nib = count_reg[3:0];
    end else begin : g_cnt_pad
      assign count_nib = {{(4-CW){1'b0}}, count_reg};
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_ok) state_next = S_START;
      S_START: if (bit_done) state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (bit_done && bit_cnt_reg == 3'd7) state_next = S_PARITY;
      S_PARITY: if (bit_done) state_next = S_STOP;
`else
      S_DATA:  if (bit_done && bit_cnt_reg == 3'd7) state_next = S_STOP;
`endif
      S_STOP:  if (bit_done) state_next = start_ok ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic parity_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      parity_reg <= 1'b0;
    else if (pop) parity_reg <= ^head;
  end
`endif

  // FSM: outputs
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state_reg)
      S_IDLE:   busy = 1'b0;
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx = parity_reg;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // Bit timing and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      if (state_reg == S_IDLE || bit_done) baud_cnt_reg <= '0;
      else                                 baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);

      if (state_reg != S_DATA) bit_cnt_reg <= '0;
      else if (bit_done)       bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (pop)                                 shift_reg <= head;
      else if (state_reg == S_DATA && bit_done) shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // FIFO storage: no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wd[7:0];
  end

  // FIFO bookkeeping and control/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      enable_reg   <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A new overflow wins over a clear in the same cycle.
      if (ovf_event)                overflow_reg <= 1'b1;
      else if (status_wr && wd[3])  overflow_reg <= 1'b0;
      if (ctrl_wr) enable_reg <= wd[0];
    end
  end

  // Read mux
  always_comb begin
    rd = '0;
    case (sel)
      2'd1: begin
        rd[0]   = busy;
        rd[1]   = full;
        rd[2]   = empty;
        rd[3]   = overflow_reg;
        rd[7:4] = count_nib;
        rd[8]   = PARITY_CFG;
      end
      2'd2:    rd[0] = enable_reg;
      default: rd = '0;
    endcase
  end

endmodule
